// File: rtl/spram_top_formal_verification.sv
// Single-port RAM built from four address-selected banks, write-first, 1-cycle registered read.
// Optional per-word even parity storage and checking is enabled by defining SPRAM_PARITY_EN.
module spram_top_formal_verification #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  parity_error
);

  localparam int unsigned NUM_BANKS  = 4;
  localparam int unsigned BANK_AW    = ADDR_WIDTH - 2;
  localparam int unsigned BANK_DEPTH = 1 << BANK_AW;
`ifdef SPRAM_PARITY_EN
  localparam int unsigned WORD_W = DATA_WIDTH + 1;
`else
  localparam int unsigned WORD_W = DATA_WIDTH;
`endif

  logic [1:0]            bank_sel;
  logic [BANK_AW-1:0]    word_addr;
  logic [NUM_BANKS-1:0]  bank_en;
  logic [WORD_W-1:0]     wr_word;
  logic [WORD_W-1:0]     bank_rd [NUM_BANKS];
  logic [WORD_W-1:0]     rd_word;

  logic [DATA_WIDTH-1:0] read_data_d;
  logic [DATA_WIDTH-1:0] read_data_q;

  always_comb begin
    bank_sel           = addr[ADDR_WIDTH-1 -: 2];
    word_addr          = addr[BANK_AW-1:0];
    bank_en            = '0;
    bank_en[bank_sel]  = 1'b1;
`ifdef SPRAM_PARITY_EN
    wr_word = {^write_data, write_data};
`else
    wr_word = write_data;
`endif
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [WORD_W-1:0] mem_q [BANK_DEPTH];

    always_ff @(posedge clk) begin
      if (!rst && write_enable && bank_en[g]) begin
        mem_q[word_addr] <= wr_word;
      end
    end

    // Disabled banks present zero so the merge below is a plain OR.
    assign bank_rd[g] = bank_en[g] ? mem_q[word_addr] : '0;
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      rd_word = rd_word | bank_rd[i];
    end
    read_data_d = write_enable ? write_data : rd_word[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

`ifdef SPRAM_PARITY_EN
  logic parity_error_d;
  logic parity_error_q;

  always_comb begin
    parity_error_d = 1'b0;
    if (!write_enable) begin
      parity_error_d = (^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_error_q <= 1'b0;
    end else begin
      parity_error_q <= parity_error_d;
    end
  end

  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_spram_top_formal_verification.sv
// Bench for spram_top_formal_verification: directed scenarios then randomized traffic
// against an array-based memory model.
module tb_spram_top_formal_verification;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic [AW-1:0] addr;
  logic [DW-1:0] read_data;
  logic          parity_error;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem   [DEPTH];
  bit            model_valid [DEPTH];

  always #5 clk = ~clk;

  spram_top_formal_verification #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write_enable(write_enable),
    .write_data  (write_data),
    .addr        (addr),
    .read_data   (read_data),
    .parity_error(parity_error)
  );

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, let the edge happen, then compare against the model.
  task automatic step(input string tag, input logic r, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic exp_pe = 1'b0);
    logic [DW-1:0] exp_rd;
    bit            known;
    rst = r; write_enable = w; addr = a; write_data = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp_rd = '0;
      known  = 1'b1;
    end else if (w) begin
      model_mem[a]   = d;
      model_valid[a] = 1'b1;
      exp_rd         = d;
      known          = 1'b1;
    end else begin
      exp_rd = model_mem[a];
      known  = model_valid[a];
    end
    if (known) check_val({tag, ".read_data"}, read_data, exp_rd);
    check_bit({tag, ".parity_error"}, parity_error, exp_pe);
  endtask

  logic [AW-1:0] dir_addr [6];
  logic [AW-1:0] pool     [12];
  logic [AW-1:0] ra;
  logic [DW-1:0] rd;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model_valid[i] = 1'b0;
    rst = 1'b1; write_enable = 1'b0; write_data = '0; addr = '0;

    step("reset0", 1'b1, 1'b0, 11'h000, 8'h00);
    step("reset1", 1'b1, 1'b0, 11'h000, 8'h00);

    dir_addr[0] = 11'h000; dir_addr[1] = 11'h008; dir_addr[2] = 11'h080;
    dir_addr[3] = 11'h200; dir_addr[4] = 11'h400; dir_addr[5] = 11'h401;
    for (int i = 0; i < 6; i++) step("dir_wr", 1'b0, 1'b1, dir_addr[i], DW'(i));
    for (int i = 0; i < 6; i++) begin
      step("dir_rd", 1'b0, 1'b0, dir_addr[i], 8'h00);
      check_val("dir_rd_const", read_data, DW'(i));
    end
    step("rd_zero", 1'b0, 1'b0, 11'h000, 8'h00);
    check_val("rd_zero_const", read_data, 8'h00);

    step("ovr_wr", 1'b0, 1'b1, 11'h401, 8'h06);
    step("ovr_rd", 1'b0, 1'b0, 11'h401, 8'h00);
    check_val("ovr_rd_const", read_data, 8'h06);
    step("nbr_rd", 1'b0, 1'b0, 11'h400, 8'h00);
    check_val("nbr_rd_const", read_data, 8'h04);

    step("top_wr", 1'b0, 1'b1, 11'h7FF, 8'hA5);
    step("rst_wr", 1'b1, 1'b1, 11'h7FF, 8'hFF);
    check_val("rst_wr_const", read_data, 8'h00);
    step("post_rst_rd", 1'b0, 1'b0, 11'h7FF, 8'h00);
    check_val("post_rst_const", read_data, 8'hA5);

`ifdef SPRAM_PARITY_EN
    step("par_clean", 1'b0, 1'b0, 11'h008, 8'h00, 1'b0);
    dut.g_bank[0].mem_q[8] = dut.g_bank[0].mem_q[8] ^ 9'h001;
    model_mem[8] = model_mem[8] ^ 8'h01;
    step("par_flip", 1'b0, 1'b0, 11'h008, 8'h00, 1'b1);
    step("par_ok", 1'b0, 1'b0, 11'h000, 8'h00, 1'b0);
`endif

    pool[0] = 11'h000; pool[1]  = 11'h1FF; pool[2]  = 11'h200; pool[3]  = 11'h3FF;
    pool[4] = 11'h400; pool[5]  = 11'h5FF; pool[6]  = 11'h600; pool[7]  = 11'h7FF;
    for (int i = 8; i < 12; i++) pool[i] = AW'($urandom_range(0, DEPTH - 1));
    for (int i = 0; i < 600; i++) begin
      ra = (($urandom % 4) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : pool[$urandom % 12];
      rd = DW'($urandom);
      step("rand", ($urandom % 40) == 0, ($urandom % 2) == 0, ra, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
